audio_panner: RTL

Splits one mono 18-bit signed audio stream into left/right outputs with complementary 5-bit gains, which is the fan-out counterpart of the two-input mixer. It sits between the AC97 sample source and the stereo output path. Pan position is stepped by two level inputs from debounced buttons. The applied gain ramps toward the target one step at a time so that pan changes produce no zipper noise. A small FSM pipelines each sample strobe into a one-cycle output-valid pulse.

---
 rtl/audio_pkg.sv | 18 +
 rtl/pan_ramp.sv | 86 ++++++++
 rtl/audio_panner.sv | 88 ++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared widths, gain constants and FSM state encoding for the audio panner.
package audio_pkg;

    localparam int unsigned SAMPLE_W    = 18;
    localparam int unsigned GAIN_W      = 5;
    localparam int unsigned GAIN_MAX    = 31;
    localparam int unsigned GAIN_CENTER = 16;
    localparam int unsigned PROD_W      = 23;
    localparam int unsigned SHIFT       = 5;
    localparam int unsigned CNT_W       = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/pan_ramp.sv
// Button edge detect, pan target and applied pan position.
// PANNER_RAMP_EN selects a gradual per-sample ramp; otherwise pan_pos tracks the target directly.
module pan_ramp
    import audio_pkg::*;
#(
    parameter int unsigned RAMP_SAMPLES = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pan_right,
    input  logic              pan_left,
`ifdef PANNER_RAMP_EN
    input  logic              sample_acc,
`endif
    output logic [GAIN_W-1:0] pan_pos
);

    generate
        if (RAMP_SAMPLES < 1 || RAMP_SAMPLES > 1023) begin : g_bad_ramp
            $error("pan_ramp: RAMP_SAMPLES must be in 1..1023");
        end
    endgenerate

    logic              right_q;
    logic              left_q;
    logic              rise_r_c;
    logic              rise_l_c;
    logic [GAIN_W-1:0] target_q;
    logic [GAIN_W-1:0] target_nxt_c;

    assign rise_r_c = pan_right & ~right_q;
    assign rise_l_c = pan_left & ~left_q;

    // Simultaneous edges cancel; both directions saturate.
    always_comb begin
        target_nxt_c = target_q;
        if (rise_r_c && !rise_l_c && target_q != GAIN_W'(GAIN_MAX)) begin
            target_nxt_c = target_q + GAIN_W'(1);
        end else if (rise_l_c && !rise_r_c && target_q != GAIN_W'(0)) begin
            target_nxt_c = target_q - GAIN_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            right_q  <= 1'b0;
            left_q   <= 1'b0;
            target_q <= GAIN_W'(GAIN_CENTER);
        end else begin
            right_q  <= pan_right;
            left_q   <= pan_left;
            target_q <= target_nxt_c;
        end
    end

`ifdef PANNER_RAMP_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_SAMPLES - 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [GAIN_W-1:0] pos_q;

    // Counter runs on every accepted sample; the position steps once per wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            pos_q <= GAIN_W'(GAIN_CENTER);
        end else if (sample_acc) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                if (pos_q < target_q) begin
                    pos_q <= pos_q + GAIN_W'(1);
                end else if (pos_q > target_q) begin
                    pos_q <= pos_q - GAIN_W'(1);
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pan_pos = pos_q;
`else
    assign pan_pos = target_q;
`endif

endmodule

// File: rtl/audio_panner.sv
// Mono-to-stereo panner: complementary 5-bit gains, three-stage capture/multiply/output pipeline.
// Optional gradual pan ramp enabled by defining PANNER_RAMP_EN.
module audio_panner
    import audio_pkg::*;
#(
    parameter int unsigned RAMP_SAMPLES = 64
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic signed [SAMPLE_W-1:0] audio_in,
    input  logic                       ready,
    input  logic                       pan_right,
    input  logic                       pan_left,
    output logic signed [SAMPLE_W-1:0] audio_out_l,
    output logic signed [SAMPLE_W-1:0] audio_out_r,
    output logic                       out_valid,
    output logic        [GAIN_W-1:0]   pan_pos
);

    state_t                     state_q;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic        [GAIN_W-1:0]   pos_q;
    logic signed [PROD_W-1:0]   prod_l_q;
    logic signed [PROD_W-1:0]   prod_r_q;
    logic        [GAIN_W-1:0]   gain_l_c;
    logic signed [PROD_W-1:0]   mul_l_c;
    logic signed [PROD_W-1:0]   mul_r_c;

`ifdef PANNER_RAMP_EN
    logic sample_acc_c;
    assign sample_acc_c = (state_q == IDLE) && ready;
`endif

    pan_ramp #(
        .RAMP_SAMPLES(RAMP_SAMPLES)
    ) u_pan_ramp (
        .clock     (clock),
        .reset_n   (reset_n),
        .pan_right (pan_right),
        .pan_left  (pan_left),
`ifdef PANNER_RAMP_EN
        .sample_acc(sample_acc_c),
`endif
        .pan_pos   (pan_pos)
    );

    // Gains are zero-extended to product width so the multiply stays signed and cannot overflow.
    assign gain_l_c = GAIN_W'(GAIN_MAX) - pos_q;
    assign mul_l_c  = $signed(PROD_W'(gain_l_c)) * PROD_W'(sample_q);
    assign mul_r_c  = $signed(PROD_W'(pos_q)) * PROD_W'(sample_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            pos_q       <= GAIN_W'(GAIN_CENTER);
            prod_l_q    <= '0;
            prod_r_q    <= '0;
            audio_out_l <= '0;
            audio_out_r <= '0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ready) begin
                        sample_q <= audio_in;
                        pos_q    <= pan_pos;
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    prod_l_q <= mul_l_c;
                    prod_r_q <= mul_r_c;
                    state_q  <= OUT;
                end
                OUT: begin
                    audio_out_l <= SAMPLE_W'(prod_l_q >>> SHIFT);
                    audio_out_r <= SAMPLE_W'(prod_r_q >>> SHIFT);
                    out_valid   <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
